// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the shift sequencer: op codes, shift-register modes and FSM states.
package shift_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_ROTR = 2'b11
    } op_t;

    localparam logic [1:0] S_HOLD  = 2'b00;
    localparam logic [1:0] S_RIGHT = 2'b01;
    localparam logic [1:0] S_LEFT  = 2'b10;
    localparam logic [1:0] S_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/shift-register bundle between the datapath, the sequencer and the shift register.
interface shift_sequencer_if
    import shift_sequencer_pkg::*;
#(
    parameter int N = 4,
    parameter int W = $clog2(N)
);
    logic         start;
    op_t          op;
    logic [W-1:0] shamt;
    logic [N-1:0] din;
    logic [N-1:0] q_in;
    logic [1:0]   s;
    logic [N-1:0] value;
    logic         MSB;
    logic         LSB;
    logic         busy;
    logic         done;

    modport master (
        output start, op, shamt, din, q_in,
        input  s, value, MSB, LSB, busy, done
    );

    modport slave (
        input  start, op, shamt, din, q_in,
        output s, value, MSB, LSB, busy, done
    );
endinterface

// File: rtl/Universa_Shift_Register.sv
// 2-bit-mode universal shift register: 00 hold, 01 right (MSB fill), 10 left (LSB fill), 11 load.
module Universa_Shift_Register #(
    parameter int N = 4
) (
    input  logic         CLK,
    input  logic         Clear,
    input  logic [1:0]   s,
    input  logic [N-1:0] value,
    input  logic         MSB,
    input  logic         LSB,
    output logic [N-1:0] Q
);
    always_ff @(posedge CLK or negedge Clear) begin
        if (!Clear) begin
            Q <= '0;
        end else begin
            case (s)
                2'b01:   Q <= {MSB, Q[N-1:1]};
                2'b10:   Q <= {Q[N-2:0], LSB};
                2'b11:   Q <= value;
                default: Q <= Q;
            endcase
        end
    end
endmodule

// File: rtl/shift_sequencer.sv
// Sequences one shift request into per-cycle s/value/MSB/LSB for a universal shift register,
// using the register's Q as feedback for arithmetic and rotate fill.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic             CLK,
    input  logic             Clear,
    shift_sequencer_if.slave bus
);
    state_t       state;
    state_t       state_next;
    logic [W-1:0] cnt;
    op_t          op_q;
    logic [N-1:0] din_q;

    always_ff @(posedge CLK or negedge Clear) begin
        if (!Clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK or negedge Clear) begin
        if (!Clear) begin
            cnt   <= '0;
            op_q  <= OP_SLL;
            din_q <= '0;
        end else if (state == ST_IDLE && bus.start) begin
            cnt   <= bus.shamt;
            op_q  <= bus.op;
            din_q <= bus.din;
        end else if (state == ST_SHIFT) begin
            cnt   <= cnt - W'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (bus.start) state_next = ST_LOAD;
            ST_LOAD:  state_next = (cnt != '0) ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (cnt == W'(1)) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Fill bits come from the live register contents, so SRA/ROTR track Q each cycle.
    always_comb begin
        bus.s     = S_HOLD;
        bus.value = din_q;
        bus.MSB   = 1'b0;
        bus.LSB   = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            ST_LOAD: begin
                bus.s    = S_LOAD;
                bus.busy = 1'b1;
            end
            ST_SHIFT: begin
                bus.busy = 1'b1;
                case (op_q)
                    OP_SLL:  bus.s = S_LEFT;
                    OP_SRL:  bus.s = S_RIGHT;
                    OP_SRA: begin
                        bus.s   = S_RIGHT;
                        bus.MSB = bus.q_in[N-1];
                    end
                    OP_ROTR: begin
                        bus.s   = S_RIGHT;
                        bus.MSB = bus.q_in[0];
                    end
                    default: bus.s = S_HOLD;
                endcase
            end
            ST_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench: shift_sequencer closed-loop with the universal shift register, N=8.
module tb_shift_sequencer;
    import shift_sequencer_pkg::*;

    localparam int N = 8;
    localparam int W = 3;

    logic         CLK = 1'b0;
    logic         Clear = 1'b0;
    logic [N-1:0] q;
    int           n_tests = 0;
    int           n_fail = 0;

    shift_sequencer_if #(.N(N), .W(W)) bus ();

    shift_sequencer #(.N(N), .W(W)) dut (
        .CLK   (CLK),
        .Clear (Clear),
        .bus   (bus)
    );

    Universa_Shift_Register #(.N(N)) sreg (
        .CLK   (CLK),
        .Clear (Clear),
        .s     (bus.s),
        .value (bus.value),
        .MSB   (bus.MSB),
        .LSB   (bus.LSB),
        .Q     (q)
    );

    assign bus.q_in = q;

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input op_t o, input int unsigned sh,
                       input logic [N-1:0] d, input logic [N-1:0] expq, input bit poke);
        int unsigned cycles;
        int unsigned shifts;
        int unsigned lsb_bad;
        int unsigned busy_bad;
        bit          seen_done;
        @(negedge CLK);
        bus.start = 1'b1;
        bus.op    = o;
        bus.shamt = W'(sh);
        bus.din   = d;
        @(posedge CLK);
        #1;
        bus.start = 1'b0;
        bus.op    = op_t'(~o);
        bus.shamt = '1;
        bus.din   = ~d;
        cycles = 0; shifts = 0; lsb_bad = 0; busy_bad = 0; seen_done = 1'b0;
        while (!seen_done && cycles < 40) begin
            @(negedge CLK);
            cycles++;
            if (cycles == 1) begin
                check({tag, " load_s"}, 32'(bus.s), 32'(S_LOAD));
                check({tag, " load_value"}, 32'(bus.value), 32'(d));
            end
            if (!bus.busy) busy_bad++;
            if (bus.s == S_LEFT || bus.s == S_RIGHT) shifts++;
            if (bus.s == S_LEFT && bus.LSB) lsb_bad++;
            if (bus.done) seen_done = 1'b1;
            if (poke) begin
                bus.start = 1'b1;
                bus.op    = OP_SLL;
                bus.shamt = W'(1);
                bus.din   = 8'hA5;
            end
        end
        check({tag, " done_seen"}, 32'(seen_done), 32'd1);
        check({tag, " latency"}, cycles, sh + 2);
        check({tag, " shifts"}, shifts, sh);
        check({tag, " q"}, 32'(q), 32'(expq));
        check({tag, " busy_profile"}, busy_bad, 0);
        check({tag, " lsb_fill"}, lsb_bad, 0);
        @(negedge CLK);
        bus.start = 1'b0;
        check({tag, " idle_busy"}, 32'(bus.busy), 0);
        check({tag, " idle_s"}, 32'(bus.s), 32'(S_HOLD));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = OP_SLL;
        bus.shamt = '0;
        bus.din   = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst s", 32'(bus.s), 0);
        check("rst value", 32'(bus.value), 0);
        check("rst msb_lsb", {bus.MSB, bus.LSB}, 0);
        check("rst busy_done", {bus.busy, bus.done}, 0);
        check("rst q", 32'(q), 0);
        @(negedge CLK);
        Clear = 1'b1;

        run("sll3",  OP_SLL,  3, 8'h81, 8'h08, 1'b0);
        run("sra2",  OP_SRA,  2, 8'h90, 8'hE4, 1'b0);
        run("srl2",  OP_SRL,  2, 8'h90, 8'h24, 1'b0);
        run("rotr1", OP_ROTR, 1, 8'h01, 8'h80, 1'b0);
        run("sh0",   OP_SRA,  0, 8'h5A, 8'h5A, 1'b0);
        run("poke",  OP_SLL,  3, 8'h81, 8'h08, 1'b1);
        run("rotr3", OP_ROTR, 3, 8'h96, 8'hD2, 1'b0);
        run("sll7",  OP_SLL,  7, 8'hFF, 8'h80, 1'b0);
        run("sra7p", OP_SRA,  7, 8'h7F, 8'h00, 1'b0);
        run("sra7n", OP_SRA,  7, 8'h80, 8'hFF, 1'b0);

        // Clear lands in the second SHIFT cycle of a 5-step left shift.
        @(negedge CLK);
        bus.start = 1'b1;
        bus.op    = OP_SLL;
        bus.shamt = W'(5);
        bus.din   = 8'h81;
        @(posedge CLK);
        #1;
        bus.start = 1'b0;
        repeat (3) @(negedge CLK);
        check("clr pre_s", 32'(bus.s), 32'(S_LEFT));
        check("clr pre_q", 32'(q), 32'h02);
        Clear = 1'b0;
        #1;
        check("clr s", 32'(bus.s), 0);
        check("clr busy", 32'(bus.busy), 0);
        check("clr done", 32'(bus.done), 0);
        check("clr value", 32'(bus.value), 0);
        check("clr q", 32'(q), 0);
        @(negedge CLK);
        Clear = 1'b1;
        run("after_clr", OP_SRL, 4, 8'hF0, 8'h0F, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
